// File: rtl/kronos_mem_arb_pkg.sv
// Shared types for the kronos memory-port arbiter: FSM state encoding and the
// full byte-enable constant used on fetch grants.
package kronos_mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GNT_I,
    ARB_GNT_D
  } arb_state_e;

  localparam logic [3:0] MASK_ALL = 4'hF;

endpackage

// File: rtl/kronos_mem_arb_timer.sv
// Per-transaction ack timeout counter; expire is high in the TIMEOUT-th cycle
// after the last clear, and never when TIMEOUT is 0.
module kronos_arb_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CNT_W-1:0] timer;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      timer <= '0;
    end else if (enable) begin
      timer <= timer + 1'b1;
    end
  end

  assign expire = (TIMEOUT != 0) && (timer == LAST);

endmodule

// File: rtl/kronos_mem_arb.sv
// Shares one memory port between instruction fetch and the load/store unit.
// Data wins by default; a starvation counter and an ack timeout bound latency.
module kronos_mem_arb
  import kronos_mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_addr,
  input  logic        instr_req,
  output logic [31:0] instr_data,
  output logic        instr_ack,
  output logic        instr_err,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wr_data,
  input  logic [3:0]  data_mask,
  input  logic        data_wr_en,
  input  logic        data_req,
  output logic [31:0] data_rd_data,
  output logic        data_ack,
  output logic        data_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic [3:0]  mem_mask,
  output logic        mem_wr_en,
  output logic        mem_req,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_ack
);

  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  arb_state_e    state;
  logic [SW-1:0] starve_cnt;
  logic          expire;
  logic          gnt_i;
  logic          gnt_d;
  logic          instr_win;

  kronos_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == ARB_IDLE),
    .enable ((state != ARB_IDLE) && !mem_ack),
    .expire (expire)
  );

  // Fetch only beats a pending data request once data has starved it STARVE_MAX times.
  assign instr_win = instr_req &&
                     (!data_req || ((STARVE_MAX != 0) && (starve_cnt == STARVE_LIM)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ARB_IDLE;
      mem_req     <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      mem_mask    <= '0;
      starve_cnt  <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (instr_req || data_req) begin
            mem_req <= 1'b1;
            if (instr_win) begin
              mem_addr    <= instr_addr;
              mem_wr_data <= '0;
              mem_mask    <= MASK_ALL;
              mem_wr_en   <= 1'b0;
              starve_cnt  <= '0;
              state       <= ARB_GNT_I;
            end else begin
              mem_addr    <= data_addr;
              mem_wr_data <= data_wr_data;
              mem_mask    <= data_mask;
              mem_wr_en   <= data_wr_en;
              if (instr_req && (starve_cnt != STARVE_LIM)) begin
                starve_cnt <= starve_cnt + 1'b1;
              end
              state       <= ARB_GNT_D;
            end
          end
        end
        ARB_GNT_I, ARB_GNT_D: begin
          if (mem_ack || expire) begin
            mem_req <= 1'b0;
            state   <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // Completion is combinational so the owner sees its ack in the same cycle as mem_ack.
  assign gnt_i = (state == ARB_GNT_I);
  assign gnt_d = (state == ARB_GNT_D);

  assign instr_ack    = gnt_i && (mem_ack || expire);
  assign instr_err    = gnt_i && !mem_ack && expire;
  assign instr_data   = (gnt_i && mem_ack) ? mem_rd_data : '0;

  assign data_ack     = gnt_d && (mem_ack || expire);
  assign data_err     = gnt_d && !mem_ack && expire;
  assign data_rd_data = (gnt_d && mem_ack) ? mem_rd_data : '0;

endmodule
